// File: rtl/ntt_iter_engine.sv
// ntt_iter_engine
//   Iterative radix-2 NTT engine, forward or inverse, single in-place RAM.
//   Coefficients arrive in natural order and are stored bit-reversed. The
//   engine then runs Cooley-Tukey DIT butterflies at 5 cycles each, does an
//   optional n^-1 scaling pass at 2 cycles per word, and streams the results
//   out in natural order.
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a transform (honoured in IDLE only)
//   inverse, q, ninv  : mode, modulus and N^-1 mod q, latched on start
//   in_valid/in_ready/in_data    : coefficient input stream (LOAD only)
//   tw_addr / tw_data : external twiddle ROM {inverse, k}; data one cycle later
//   out_valid/out_ready/out_data : coefficient output stream (UNLOAD only)
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse after the last output handshake
module ntt_iter_engine #(
  parameter int DATA_W = 16,
  parameter int LOG_N  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inverse,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] ninv,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [LOG_N-1:0]  tw_addr,
  input  logic [DATA_W-1:0] tw_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int N  = 1 << LOG_N;
  localparam int SW = $clog2(LOG_N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BFLY, S_SCALE, S_UNLOAD
  } state_t;

  state_t            state_q, state_d;
  logic              inv_q, inv_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [DATA_W-1:0] ninv_q, ninv_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] t_q, t_d;
  logic [LOG_N-1:0]  cnt_q, cnt_d;
  logic [LOG_N-2:0]  bidx_q, bidx_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [2:0]        phase_q, phase_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] ram_q [N];
  logic              ram_we;
  logic [LOG_N-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic [LOG_N-1:0]  mask, idx_i, idx_j, load_addr;
  logic [LOG_N-2:0]  tw_k;

  function automatic logic [DATA_W-1:0] mulmod(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [DATA_W-1:0] m);
    return DATA_W'(({{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y})
                   % {{DATA_W{1'b0}}, m});
  endfunction

  function automatic logic [DATA_W-1:0] addmod(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [DATA_W-1:0] m);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] submod(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [DATA_W-1:0] m);
    if (x >= y) return x - y;
    return DATA_W'({1'b0, x} + {1'b0, m} - {1'b0, y});
  endfunction

  // Butterfly number b within a stage maps to i = group*2*half + k, where
  // the low 'stage' bits of b are k and the remaining bits are the group.
  always_comb begin : addr_gen
    mask      = (LOG_N'(1) << stage_q) - LOG_N'(1);
    idx_i     = (({1'b0, bidx_q} & ~mask) << 1) | ({1'b0, bidx_q} & mask);
    idx_j     = idx_i | (LOG_N'(1) << stage_q);
    tw_k      = (bidx_q & mask[LOG_N-2:0]) << (SW'(LOG_N - 1) - stage_q);
    load_addr = '0;
    for (int unsigned n = 0; n < LOG_N; n++) begin
      load_addr[n] = cnt_q[LOG_N-1-n];
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    inv_d     = inv_q;
    mod_d     = mod_q;
    ninv_d    = ninv_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    stage_d   = stage_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    tw_addr   = '0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // The done cycle is spent in IDLE but must not accept a new start.
        if (start && !done_q) begin
          state_d = S_LOAD;
          inv_d   = inverse;
          mod_d   = q;
          ninv_d  = ninv;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we    = 1'b1;
          ram_waddr = load_addr;
          ram_wdata = in_data;
          cnt_d     = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = S_BFLY;
            bidx_d  = '0;
            stage_d = '0;
            phase_d = '0;
          end
        end
      end

      S_BFLY: begin
        // Address held for the whole butterfly so tw_data is stable by C2.
        tw_addr = {inv_q, tw_k};
        phase_d = phase_q + 3'd1;
        case (phase_q)
          3'd0: a_d = ram_q[idx_i];
          3'd1: b_d = ram_q[idx_j];
          3'd2: t_d = mulmod(tw_data, b_q, mod_q);
          3'd3: begin
            ram_we    = 1'b1;
            ram_waddr = idx_i;
            ram_wdata = addmod(a_q, t_q, mod_q);
          end
          default: begin
            ram_we    = 1'b1;
            ram_waddr = idx_j;
            ram_wdata = submod(a_q, t_q, mod_q);
            phase_d   = '0;
            bidx_d    = bidx_q + 1'b1;
            if (&bidx_q) begin
              stage_d = stage_q + 1'b1;
              if (stage_q == SW'(LOG_N - 1)) begin
                state_d = inv_q ? S_SCALE : S_UNLOAD;
                stage_d = '0;
                cnt_d   = '0;
              end
            end
          end
        endcase
      end

      S_SCALE: begin
        if (phase_q == 3'd0) begin
          a_d     = ram_q[cnt_q];
          phase_d = 3'd1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = cnt_q;
          ram_wdata = mulmod(a_q, ninv_q, mod_q);
          phase_d   = '0;
          cnt_d     = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_UNLOAD;
        end
      end

      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = ram_q[cnt_q];
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      mod_q   <= '0;
      ninv_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      stage_q <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      mod_q   <= mod_d;
      ninv_q  <= ninv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      stage_q <= stage_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign done = done_q;

endmodule

// File: tb/tb_ntt_iter_engine.sv
// Testbench for ntt_iter_engine. Two instances share one stimulus port set:
// a small one (LOG_N=2, q=17) and a large one (LOG_N=8, q=7681); 'sel'
// chooses which is active. Expected outputs come from literal vectors and
// from a direct O(N^2) DFT model X[k] = scale * sum x[m] w^(m*k) mod q.
module tb_ntt_iter_engine;

  localparam int DW = 16;
  localparam int LS = 2;
  localparam int LL = 8;
  localparam longint QL = 7681;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, inverse, in_valid, out_ready, sel;
  logic [DW-1:0] q, ninv, in_data;

  logic          in_ready_s, out_valid_s, busy_s, done_s;
  logic [DW-1:0] out_data_s, tw_data_s;
  logic [LS-1:0] tw_addr_s;
  logic          in_ready_l, out_valid_l, busy_l, done_l;
  logic [DW-1:0] out_data_l, tw_data_l;
  logic [LL-1:0] tw_addr_l;

  ntt_iter_engine #(.DATA_W(DW), .LOG_N(LS)) dut_s (
    .clk(clk), .reset(reset), .start(start & ~sel), .inverse(inverse),
    .q(q), .ninv(ninv), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(in_ready_s), .tw_addr(tw_addr_s), .tw_data(tw_data_s),
    .out_valid(out_valid_s), .out_data(out_data_s),
    .out_ready(out_ready & ~sel), .busy(busy_s), .done(done_s)
  );

  ntt_iter_engine #(.DATA_W(DW), .LOG_N(LL)) dut_l (
    .clk(clk), .reset(reset), .start(start & sel), .inverse(inverse),
    .q(q), .ninv(ninv), .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(in_ready_l), .tw_addr(tw_addr_l), .tw_data(tw_data_l),
    .out_valid(out_valid_l), .out_data(out_data_l),
    .out_ready(out_ready & sel), .busy(busy_l), .done(done_l)
  );

  logic          in_ready_m, out_valid_m, busy_m, done_m;
  logic [DW-1:0] out_data_m;
  logic [LL-1:0] tw_addr_m;
  assign in_ready_m  = sel ? in_ready_l  : in_ready_s;
  assign out_valid_m = sel ? out_valid_l : out_valid_s;
  assign busy_m      = sel ? busy_l      : busy_s;
  assign done_m      = sel ? done_l      : done_s;
  assign out_data_m  = sel ? out_data_l  : out_data_s;
  assign tw_addr_m   = sel ? tw_addr_l   : {{(LL-LS){1'b0}}, tw_addr_s};

  // Synchronous twiddle ROMs: data appears the cycle after the address.
  logic [DW-1:0] rom_s [4];
  logic [DW-1:0] rom_l [256];
  always @(posedge clk) begin
    tw_data_s <= rom_s[tw_addr_s];
    tw_data_l <= rom_l[tw_addr_l];
  end

  int checks = 0;
  int errors = 0;
  int in_hs = 0, out_hs = 0, done_cnt = 0, comp_cyc = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] vin [256];
  logic [DW-1:0] vexp [256];
  longint model_in [256];
  longint model_out [256];
  longint wp [256];
  longint wl, wl_inv, ninv_l;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint powmod(input longint b, input longint e,
                                    input longint m);
    longint r = 1;
    b = b % m;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % m;
      b = (b * b) % m;
      e = e / 2;
    end
    return r;
  endfunction

  // Direct DFT by definition, independent of butterfly ordering.
  task automatic model_ntt(input int n, input longint w, input longint qm,
                           input longint scale);
    longint acc;
    for (int m = 0; m < n; m++) wp[m] = powmod(w, m, qm);
    for (int k = 0; k < n; k++) begin
      acc = 0;
      for (int m = 0; m < n; m++) acc = (acc + model_in[m] * wp[(m * k) % n]) % qm;
      model_out[k] = (acc * scale) % qm;
    end
  endtask

  // Single compare process: per-cycle output checks and scoreboard pops.
  initial begin : compare
    logic          held_valid;
    logic [DW-1:0] held_data;
    logic [DW-1:0] e;
    held_valid = 1'b0;
    held_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_valid = 1'b0;
      end else begin
        if (!busy_m)
          check("idle_outputs_zero", {in_ready_m, out_valid_m, out_data_m, tw_addr_m}, 0);
        if (done_m) begin
          done_cnt++;
          check("busy_low_in_done", busy_m, 0);
        end
        if (held_valid) begin
          check("stall_valid_held", out_valid_m, 1);
          check("stall_data_held", out_data_m, held_data);
        end
        held_valid = out_valid_m && !out_ready;
        held_data  = out_data_m;
        if (in_valid && in_ready_m) in_hs++;
        if (busy_m && !in_ready_m && !out_valid_m) comp_cyc++;
        if (out_valid_m && out_ready) begin
          out_hs++;
          check("expect_available", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data_m, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xform(input string tag, input logic s, input logic inv,
                           input logic [DW-1:0] qv, input logic [DW-1:0] nv,
                           input int n, input int lg, input bit gaps,
                           input bit extras);
    int in0, out0, d0, c0, k, guard;
    bit done_seen;
    in0 = in_hs; out0 = out_hs; d0 = done_cnt; c0 = comp_cyc;
    for (int i = 0; i < n; i++) exp_q.push_back(vexp[i]);
    sel = s; inverse = inv; q = qv; ninv = nv; start = 1'b1;
    tick();
    start = 1'b0; inverse = 1'b0; q = '0; ninv = '0;
    check({tag, "_busy_after_start"}, busy_m, 1);
    check({tag, "_ready_after_start"}, in_ready_m, 1);
    k = 0; guard = 0;
    while (k < n && guard < 20 * n + 100) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = vin[k];
      start    = (extras && k == 1) ? 1'b1 : 1'b0;
      if (in_valid && in_ready_m) k++;
      tick();
      guard++;
    end
    check({tag, "_load_count"}, k, n);
    in_valid = extras ? 1'b1 : 1'b0;
    in_data  = 16'h5a5a;
    start    = 1'b0;
    guard = 0; done_seen = 0;
    while (!done_seen && guard < 50000) begin
      out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (extras && (out_hs - out0) == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      #1;
      if (done_m) begin
        done_seen = 1;
        if (extras) start = 1'b1;
      end else begin
        tick();
      end
      guard++;
    end
    check({tag, "_done_seen"}, done_seen, 1);
    tick();
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({tag, "_idle_after_done"}, busy_m, 0);
    check({tag, "_in_handshakes"}, in_hs - in0, n);
    check({tag, "_out_handshakes"}, out_hs - out0, n);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_compute_cycles"}, comp_cyc - c0, 5 * (n / 2) * lg + (inv ? 2 * n : 0));
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic set_small(input int a0, input int a1, input int a2, input int a3,
                           input int e0, input int e1, input int e2, input int e3);
    vin[0] = DW'(a0); vin[1] = DW'(a1); vin[2] = DW'(a2); vin[3] = DW'(a3);
    vexp[0] = DW'(e0); vexp[1] = DW'(e1); vexp[2] = DW'(e2); vexp[3] = DW'(e3);
  endtask

  task automatic abort_test();
    int d0, k, guard;
    d0 = done_cnt;
    set_small(1, 2, 3, 4, 10, 7, 15, 6);
    sel = 1'b0; inverse = 1'b0; q = 17; ninv = 0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 4 && guard < 100) begin
      in_valid = 1'b1;
      in_data  = vin[k];
      if (in_ready_m) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("abort_busy_before_reset", busy_m, 1);
    reset = 1'b1;
    tick();
    check("abort_outputs_zero",
          {in_ready_m, out_valid_m, out_data_m, tw_addr_m, busy_m, done_m}, 0);
    reset = 1'b0;
    repeat (10) tick();
    check("abort_no_done", done_cnt - d0, 0);
  endtask

  initial begin : stimulus
    longint wc;
    int h0;
    reset = 1'b1; start = 1'b0; inverse = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; sel = 1'b0; q = '0; ninv = '0; in_data = '0;

    rom_s[0] = 16'd1; rom_s[1] = 16'd4; rom_s[2] = 16'd1; rom_s[3] = 16'd13;
    wl = 0;
    for (int x = 2; x < 7681; x++) begin
      wc = powmod(x, 30, QL);
      if (powmod(wc, 128, QL) == QL - 1) begin
        wl = wc;
        break;
      end
    end
    wl_inv = powmod(wl, 255, QL);
    ninv_l = powmod(256, QL - 2, QL);
    for (int k = 0; k < 128; k++) begin
      rom_l[k]       = DW'(powmod(wl, k, QL));
      rom_l[128 + k] = DW'(powmod(wl_inv, k, QL));
    end

    repeat (3) tick();
    check("reset_outputs_small",
          {in_ready_s, out_valid_s, out_data_s, tw_addr_s, busy_s, done_s}, 0);
    check("reset_outputs_large",
          {in_ready_l, out_valid_l, out_data_l, tw_addr_l, busy_l, done_l}, 0);
    reset = 1'b0;
    tick();

    // Pin the model to hand-computed transforms.
    model_in[0] = 1; model_in[1] = 2; model_in[2] = 3; model_in[3] = 4;
    model_ntt(4, 4, 17, 1);
    check("model_fwd0", model_out[0], 10);
    check("model_fwd1", model_out[1], 7);
    check("model_fwd2", model_out[2], 15);
    check("model_fwd3", model_out[3], 6);
    model_in[0] = 10; model_in[1] = 7; model_in[2] = 15; model_in[3] = 6;
    model_ntt(4, 13, 17, 13);
    check("model_inv0", model_out[0], 1);
    check("model_inv1", model_out[1], 2);
    check("model_inv2", model_out[2], 3);
    check("model_inv3", model_out[3], 4);

    set_small(1, 2, 3, 4, 10, 7, 15, 6);
    run_xform("fwd4", 1'b0, 1'b0, 16'd17, 16'd0, 4, 2, 1'b0, 1'b0);
    set_small(10, 7, 15, 6, 1, 2, 3, 4);
    run_xform("inv4", 1'b0, 1'b1, 16'd17, 16'd13, 4, 2, 1'b0, 1'b0);
    set_small(1, 2, 3, 4, 10, 7, 15, 6);
    run_xform("fwd4_bp", 1'b0, 1'b0, 16'd17, 16'd0, 4, 2, 1'b1, 1'b1);

    h0 = in_hs;
    in_valid = 1'b1; in_data = 16'd9;
    repeat (5) tick();
    in_valid = 1'b0;
    check("idle_in_valid_not_consumed", in_hs - h0, 0);
    check("idle_stays_idle", busy_m, 0);

    abort_test();
    set_small(1, 2, 3, 4, 10, 7, 15, 6);
    run_xform("fwd4_after_abort", 1'b0, 1'b0, 16'd17, 16'd0, 4, 2, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      vin[i]  = (i == 0) ? 16'd7680 : 16'd0;
      vexp[i] = 16'd7680;
    end
    run_xform("delta256", 1'b1, 1'b0, 16'd7681, 16'd0, 256, 8, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      vin[i]      = DW'($urandom_range(0, 7680));
      model_in[i] = longint'(vin[i]);
    end
    model_ntt(256, wl, QL, 1);
    for (int i = 0; i < 256; i++) vexp[i] = DW'(model_out[i]);
    run_xform("fwd256", 1'b1, 1'b0, 16'd7681, 16'd0, 256, 8, 1'b1, 1'b0);

    for (int i = 0; i < 256; i++) begin
      vexp[i] = vin[i];
      vin[i]  = DW'(model_out[i]);
    end
    run_xform("inv256", 1'b1, 1'b1, 16'd7681, DW'(ninv_l), 256, 8, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
